// File: rtl/ctrl_contatore_if.sv
// Command/status bundle between control logic and the ctrl_contatore sequencer.
// The master side issues commands and programs the limit. The slave side is the sequencer.
interface ctrl_contatore_if #(
   parameter int N = 2
);
   logic         start;
   logic         pause;
   logic         stop;
   logic         periodic;
   logic [N-1:0] limit;
   logic [N-1:0] count;
   logic         cnt_en;
   logic         busy;
   logic         done;

   modport master (
      output start, pause, stop, periodic, limit,
      input  count, cnt_en, busy, done
   );

   modport slave (
      input  start, pause, stop, periodic, limit,
      output count, cnt_en, busy, done
   );
endinterface

// File: rtl/ctrl_contatore.sv
// Start/pause/stop sequencer for an N-bit up-counter with a terminal compare.
// It runs in one-shot or periodic (auto-reload) mode and pulses done for one cycle at terminal count.
module ctrl_contatore #(
   parameter int N = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   ctrl_contatore_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_t;

   localparam logic [N-1:0] ZERO = '0;
   localparam logic [N-1:0] ONE  = N'(1);

   state_t       state, state_next;
   logic [N-1:0] count, count_next;
   logic [N-1:0] limit_q, limit_next;
   logic         periodic_q, periodic_next;
   logic         done_q, done_next;
   logic         cnt_en;

   // NOTE: sequential state uses non-blocking assignments. Every register then updates from its pre-edge value.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         count      <= ZERO;
         limit_q    <= ZERO;
         periodic_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state      <= state_next;
         count      <= count_next;
         limit_q    <= limit_next;
         periodic_q <= periodic_next;
         done_q     <= done_next;
      end
   end

   // Counting is suppressed in the same cycle that stop or pause is raised.
   assign cnt_en = (state == RUN) && !bus.stop && !bus.pause;

   // NOTE: every signal gets a default before the case statement. This means no path can infer a latch.
   always_comb begin
      state_next    = state;
      count_next    = count;
      limit_next    = limit_q;
      periodic_next = periodic_q;
      done_next     = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.stop) begin
               count_next = ZERO;
            end else if (bus.start) begin
               state_next    = RUN;
               count_next    = ZERO;
               limit_next    = bus.limit;
               periodic_next = bus.periodic;
            end
         end

         RUN: begin
            if (bus.stop) begin
               state_next = IDLE;
               count_next = ZERO;
            end else if (bus.pause) begin
               state_next = PAUSE;
            end else if (count == limit_q) begin
               // Reload comes from the compare and never from natural wrap. This means limit = 2^N-1 still fires.
               done_next = 1'b1;
               if (periodic_q) begin
                  count_next = ZERO;
               end else begin
                  state_next = DONE;
               end
            end else begin
               count_next = count + ONE;
            end
         end

         PAUSE: begin
            if (bus.stop) begin
               state_next = IDLE;
               count_next = ZERO;
            end else if (bus.start) begin
               state_next = RUN;
            end
         end

         DONE: begin
            if (bus.stop) begin
               state_next = IDLE;
               count_next = ZERO;
            end else if (bus.start) begin
               state_next    = RUN;
               count_next    = ZERO;
               limit_next    = bus.limit;
               periodic_next = bus.periodic;
            end
         end

         default: begin
            state_next = IDLE;
            count_next = ZERO;
         end
      endcase
   end

   assign bus.count  = count;
   assign bus.cnt_en = cnt_en;
   assign bus.busy   = (state == RUN) || (state == PAUSE);
   assign bus.done   = done_q;

endmodule

// File: tb/tb_ctrl_contatore.sv
// Directed bench for ctrl_contatore (N=2). It uses a cycle-level reference model and per-cycle compares.
// It also checks literal expectations at the key points of each scenario.
module tb_ctrl_contatore;
   localparam int N = 2;

   logic clock;
   logic reset_n;

   ctrl_contatore_if #(.N(N)) bus ();

   ctrl_contatore #(.N(N)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Reference model. It tracks whether the counter is running, paused or finished, plus the latched settings.
   bit m_run, m_paused, m_fin, m_per, m_done;
   int m_count, m_limit;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_run = 0; m_paused = 0; m_fin = 0; m_per = 0; m_done = 0;
         m_count = 0; m_limit = 0;
      end else begin
         bit nd;
         nd = 0;
         if (bus.stop) begin
            m_run = 0; m_paused = 0; m_fin = 0; m_count = 0;
         end else if (bus.start && !m_run) begin
            if (m_paused) begin
               m_paused = 0; m_run = 1;
            end else begin
               m_run = 1; m_fin = 0; m_count = 0;
               m_limit = int'(bus.limit); m_per = bus.periodic;
            end
         end else if (m_run && bus.pause) begin
            m_run = 0; m_paused = 1;
         end else if (m_run) begin
            if (m_count == m_limit) begin
               nd = 1;
               if (m_per) m_count = 0;
               else begin m_run = 0; m_fin = 1; end
            end else begin
               m_count = (m_count + 1) % (1 << N);
            end
         end
         m_done = nd;
      end
   end

   always @(negedge clock) begin
      if (reset_n) begin
         check("cmp_count",  int'(bus.count),  m_count);
         check("cmp_busy",   int'(bus.busy),   int'(m_run || m_paused));
         check("cmp_done",   int'(bus.done),   int'(m_done));
         check("cmp_cnt_en", int'(bus.cnt_en), int'(m_run && !bus.stop && !bus.pause));
      end
   end

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) @(posedge clock);
      #1;
   endtask

   task automatic cmd(input bit s, input bit p, input bit t);
      bus.start = s; bus.pause = p; bus.stop = t;
   endtask

   task automatic lit(input string name, input int c, input int b, input int d);
      check({name, "_count"}, int'(bus.count), c);
      check({name, "_busy"},  int'(bus.busy),  b);
      check({name, "_done"},  int'(bus.done),  d);
   endtask

   initial begin
      reset_n = 1'b0;
      cmd(0, 0, 0);
      bus.periodic = 1'b0;
      bus.limit    = '0;
      #1;
      lit("reset", 0, 0, 0);
      check("reset_cnt_en", int'(bus.cnt_en), 0);
      step(2);
      reset_n = 1'b1;
      step(1);

      // One-shot, limit 3
      bus.limit = 2'd3; bus.periodic = 1'b0; cmd(1, 0, 0);
      step(1); lit("os_start", 0, 1, 0);
      cmd(0, 0, 0);
      step(3); lit("os_at3", 3, 1, 0);
      step(1); lit("os_done", 3, 0, 1);
      step(1); lit("os_hold", 3, 0, 0);

      // Periodic, limit 2. Limit changes while busy must be ignored.
      bus.limit = 2'd2; bus.periodic = 1'b1; cmd(1, 0, 0);
      step(1); lit("per_start", 0, 1, 0);
      cmd(0, 0, 0); bus.limit = 2'd0; bus.periodic = 1'b0;
      step(3); lit("per_reload", 0, 1, 1);
      step(1); lit("per_after", 1, 1, 0);
      step(2); lit("per_reload2", 0, 1, 1);
      cmd(0, 0, 1);
      step(1); lit("stop", 0, 0, 0);
      cmd(0, 0, 0);

      // Pause/resume, one-shot, limit 3
      bus.limit = 2'd3; bus.periodic = 1'b0; cmd(1, 0, 0);
      step(1); cmd(0, 0, 0);
      step(1);
      cmd(0, 1, 0); #1;
      check("pause_cnt_en", int'(bus.cnt_en), 0);
      step(4); lit("paused", 1, 1, 0);
      cmd(1, 0, 0);
      step(1); lit("resume", 1, 1, 0);
      cmd(0, 0, 0);
      step(2); lit("resume_at3", 3, 1, 0);
      step(1); lit("resume_done", 3, 0, 1);

      // Priority: stop+start+pause during RUN, then start+pause from IDLE
      cmd(1, 0, 0);
      step(1); cmd(0, 0, 0);
      step(1);
      cmd(1, 1, 1);
      step(1); lit("prio_stop", 0, 0, 0);
      cmd(1, 1, 0);
      step(1); lit("prio_start", 0, 1, 0);
      cmd(0, 0, 0);
      step(1); lit("prio_run", 1, 1, 0);
      cmd(0, 0, 1); step(1); cmd(0, 0, 0);

      // limit 0 one-shot
      bus.limit = 2'd0; bus.periodic = 1'b0; cmd(1, 0, 0);
      step(1); lit("l0os_start", 0, 1, 0);
      cmd(0, 0, 0);
      step(1); lit("l0os_done", 0, 0, 1);

      // limit 0 periodic
      bus.periodic = 1'b1; cmd(1, 0, 0);
      step(1); cmd(0, 0, 0);
      step(1); lit("l0p_1", 0, 1, 1);
      step(2); lit("l0p_3", 0, 1, 1);
      cmd(0, 0, 1); step(1); cmd(0, 0, 0);

      // limit 2^N-1 periodic: terminal and wrap coincide
      bus.limit = 2'd3; bus.periodic = 1'b1; cmd(1, 0, 0);
      step(1); cmd(0, 0, 0);
      step(3); lit("lmax_at3", 3, 1, 0);
      step(1); lit("lmax_reload", 0, 1, 1);
      step(4); lit("lmax_reload2", 0, 1, 1);
      cmd(0, 0, 1); step(1); cmd(0, 0, 0);

      // Asynchronous reset mid-run at count 2
      bus.periodic = 1'b0; cmd(1, 0, 0);
      step(1); cmd(0, 0, 0);
      step(2);
      check("pre_reset_count", int'(bus.count), 2);
      #2 reset_n = 1'b0;
      #1 lit("async_reset", 0, 0, 0);
      step(2);
      reset_n = 1'b1;
      step(2); lit("post_reset", 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
